// File: rtl/fixed_to_floating_point_converter.sv
// Three-stage signed fixed-point to {sign|exponent|fraction} converter with a
// global-stall valid/ready pipeline. FIXED_TO_FP_SATURATE_EN clamps overflow to max finite.
module fixed_to_floating_point_converter #(
  parameter int EXP_WIDTH       = 8,
  parameter int FRAC_WIDTH      = 23,
  parameter int INT_WIDTH       = 32,
  parameter int FIXED_FRAC_BITS = 0
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [INT_WIDTH-1:0]            fix_i,
  input  logic                            valid_i,
  output logic                            ready_o,
  output logic [EXP_WIDTH+FRAC_WIDTH:0]   fp_o,
  output logic                            valid_o,
  input  logic                            ready_i
);

  localparam int FP_W    = 1 + EXP_WIDTH + FRAC_WIDTH;
  localparam int LZW     = $clog2(INT_WIDTH + 1);
  localparam int BIAS    = (1 << (EXP_WIDTH - 1)) - 1;
  localparam int EXP_MAX = (1 << EXP_WIDTH) - 1;
  localparam int EW      = 34;
  localparam int EXT_W   = INT_WIDTH + FRAC_WIDTH;
  localparam logic signed [EW-1:0] E_OFF  = EW'(INT_WIDTH - 1 + BIAS - FIXED_FRAC_BITS);
  localparam logic signed [EW-1:0] EMAX_S = EW'(EXP_MAX);

  // Handshake: an item moves in when valid_i && ready_o and out when
  // valid_o && ready_i; a held output stalls every stage together.
  logic en;
  assign en      = !valid_o || ready_i;
  assign ready_o = en;

  // Stage 1: accept
  logic                 s1_valid;
  logic [INT_WIDTH-1:0] s1_fix;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)  s1_valid <= 1'b0;
    else if (en)  s1_valid <= valid_i;
  end

  always_ff @(posedge clk_i) begin
    if (en) s1_fix <= fix_i;
  end

  // Stage 2: magnitude and leading-zero count
  logic [INT_WIDTH-1:0] mag_c;
  logic [LZW-1:0]       lzc_c;
  logic                 zero_c;

  always_comb begin
    mag_c  = s1_fix[INT_WIDTH-1] ? (~s1_fix + INT_WIDTH'(1)) : s1_fix;
    zero_c = (mag_c == '0);
    lzc_c  = LZW'(INT_WIDTH);
    for (int i = 0; i < INT_WIDTH; i++) begin
      if (mag_c[i]) lzc_c = LZW'(INT_WIDTH - 1 - i);
    end
  end

  logic                 s2_valid;
  logic                 s2_sign;
  logic                 s2_zero;
  logic [INT_WIDTH-1:0] s2_mag;
  logic [LZW-1:0]       s2_lzc;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)  s2_valid <= 1'b0;
    else if (en)  s2_valid <= s1_valid;
  end

  always_ff @(posedge clk_i) begin
    if (en) begin
      s2_sign <= s1_fix[INT_WIDTH-1];
      s2_zero <= zero_c;
      s2_mag  <= mag_c;
      s2_lzc  <= lzc_c;
    end
  end

  // Stage 3: normalise, round (ties away from zero), pack
  logic [INT_WIDTH-1:0]       norm;
  logic [EXT_W-1:0]           ext;
  logic [FRAC_WIDTH-1:0]      frac_t;
  logic                       rnd;
  logic [FRAC_WIDTH:0]        sum;
  logic                       carry;
  logic [FRAC_WIDTH-1:0]      frac_r;
  logic signed [EW-1:0]       biased;
  logic [FP_W-1:0]            fp_c;
  logic                       unused_bits;

  always_comb begin
    norm   = s2_mag << s2_lzc;
    ext    = {norm[INT_WIDTH-2:0], {(FRAC_WIDTH + 1){1'b0}}};
    frac_t = ext[EXT_W-1 -: FRAC_WIDTH];
    rnd    = ext[INT_WIDTH-1];
    sum    = {1'b0, frac_t} + (FRAC_WIDTH + 1)'(rnd);
    carry  = sum[FRAC_WIDTH];
    frac_r = sum[FRAC_WIDTH-1:0];
    biased = E_OFF - EW'(s2_lzc) + EW'(carry);
    fp_c   = '0;
    if (s2_zero) begin
      fp_c = '0;
    end else if (biased <= 0) begin
      fp_c = {s2_sign, {(FP_W - 1){1'b0}}};
    end else if (biased >= EMAX_S) begin
`ifdef FIXED_TO_FP_SATURATE_EN
      fp_c = {s2_sign, EXP_WIDTH'(EXP_MAX - 1), {FRAC_WIDTH{1'b1}}};
`else
      fp_c = {s2_sign, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
`endif
    end else begin
      fp_c = {s2_sign, biased[EXP_WIDTH-1:0], frac_r};
    end
  end

  assign unused_bits = ^{ext[INT_WIDTH-2:0], norm[INT_WIDTH-1]};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_o <= 1'b0;
      fp_o    <= '0;
    end else if (en) begin
      valid_o <= s2_valid;
      if (s2_valid) fp_o <= fp_c;
    end
  end

endmodule

// File: tb/tb_fixed_to_floating_point_converter.sv
// Bench for fixed_to_floating_point_converter: single-precision, half and
// half with 24 fraction bits, all fed the same directed stream.
module tb_fixed_to_floating_point_converter;

`ifdef FIXED_TO_FP_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        valid_i;
  logic        ready_i;
  logic [31:0] fix;
  logic [31:0] fp0;
  logic [15:0] fp1, fp2;
  logic        vo0, vo1, vo2;
  logic        ro0, ro1, ro2;

  fixed_to_floating_point_converter u_sp (
    .clk_i(clk), .rst_ni(rst_n), .fix_i(fix), .valid_i(valid_i), .ready_o(ro0),
    .fp_o(fp0), .valid_o(vo0), .ready_i(ready_i)
  );

  fixed_to_floating_point_converter #(.EXP_WIDTH(5), .FRAC_WIDTH(10)) u_hp (
    .clk_i(clk), .rst_ni(rst_n), .fix_i(fix), .valid_i(valid_i), .ready_o(ro1),
    .fp_o(fp1), .valid_o(vo1), .ready_i(ready_i)
  );

  fixed_to_floating_point_converter #(.EXP_WIDTH(5), .FRAC_WIDTH(10), .FIXED_FRAC_BITS(24)) u_hq (
    .clk_i(clk), .rst_ni(rst_n), .fix_i(fix), .valid_i(valid_i), .ready_o(ro2),
    .fp_o(fp2), .valid_o(vo2), .ready_i(ready_i)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  logic [31:0] exp_q0[$], exp_q1[$], exp_q2[$];
  logic [31:0] out_q0[$], out_q1[$], out_q2[$];
  int          acc_cyc_q[$];
  int          lat_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // Value-level model: find the leading power of two, round the real
  // mantissa to FW bits (ties away), then classify the biased exponent.
  function automatic logic [31:0] model(input logic [31:0] x, input int ew, input int fw, input int ffb);
    longint          v;
    longint unsigned m, q;
    int              p, be, bias, emax;
    logic [31:0]     s;
    v    = longint'($signed(x));
    s    = (v < 0) ? 32'd1 : 32'd0;
    m    = (v < 0) ? longint'(-v) : v;
    bias = (1 << (ew - 1)) - 1;
    emax = (1 << ew) - 1;
    if (m == 0) return 32'd0;
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    if (p > fw) begin
      q = m >> (p - fw);
      q = q + ((m >> (p - fw - 1)) & 64'd1);
    end else begin
      q = m << (fw - p);
    end
    if ((q >> (fw + 1)) != 0) begin
      q = q >> 1;
      p++;
    end
    be = p - ffb + bias;
    if (be <= 0) return s << (ew + fw);
    if (be >= emax) begin
      if (SAT) return (s << (ew + fw)) | 32'((emax - 1) << fw) | 32'((1 << fw) - 1);
      return (s << (ew + fw)) | 32'(emax << fw);
    end
    return (s << (ew + fw)) | 32'(be << fw) | 32'(q - (64'd1 << fw));
  endfunction

  // compare process
  logic [31:0] prev_fp[3];
  bit          prev_stall[3];

  always @(negedge clk) begin
    logic [31:0] fpa[3];
    logic        va[3];
    logic        ra[3];
    logic [31:0] e;
    int          sz;
    cyc++;
    fpa[0] = fp0; fpa[1] = {16'h0, fp1}; fpa[2] = {16'h0, fp2};
    va[0] = vo0; va[1] = vo1; va[2] = vo2;
    ra[0] = ro0; ra[1] = ro1; ra[2] = ro2;
    if (!rst_n) begin
      exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
      acc_cyc_q.delete();
      for (int d = 0; d < 3; d++) prev_stall[d] = 1'b0;
    end else begin
      for (int d = 0; d < 3; d++) begin
        check($sformatf("dut%0d_ready_o", d), {31'b0, ra[d]}, {31'b0, !va[d] || ready_i});
        if (prev_stall[d]) begin
          check($sformatf("dut%0d_hold_valid", d), {31'b0, va[d]}, 32'd1);
          check($sformatf("dut%0d_hold_fp", d), fpa[d], prev_fp[d]);
        end
        if (valid_i && ra[d]) begin
          e = model(fix, (d == 0) ? 8 : 5, (d == 0) ? 23 : 10, (d == 2) ? 24 : 0);
          case (d)
            0: begin exp_q0.push_back(e); acc_cyc_q.push_back(cyc); end
            1: exp_q1.push_back(e);
            default: exp_q2.push_back(e);
          endcase
        end
        if (va[d] && ready_i) begin
          case (d)
            0: sz = exp_q0.size();
            1: sz = exp_q1.size();
            default: sz = exp_q2.size();
          endcase
          if (sz == 0) begin
            checks++;
            $display("FAIL dut%0d_stray_emit: got %h with nothing pending, required no output", d, fpa[d]);
          end else begin
            case (d)
              0: begin
                e = exp_q0.pop_front();
                out_q0.push_back(fpa[d]);
                lat_q.push_back(cyc - acc_cyc_q.pop_front());
              end
              1: begin e = exp_q1.pop_front(); out_q1.push_back(fpa[d]); end
              default: begin e = exp_q2.pop_front(); out_q2.push_back(fpa[d]); end
            endcase
            check($sformatf("dut%0d_result", d), fpa[d], e);
          end
        end
        prev_stall[d] = va[d] && !ready_i;
        prev_fp[d]    = fpa[d];
      end
    end
  end

  // driver tasks (inputs change 1 time unit after the rising edge)
  task automatic send(input logic [31:0] v);
    logic acc;
    int   n;
    fix = v; valid_i = 1'b1; n = 0;
    do begin
      @(negedge clk); acc = ro0;
      @(posedge clk); #1; n++;
    end while (!acc && n < 50);
    if (!acc) begin
      checks++;
      $display("FAIL send_timeout: ready_o stayed 0 for %0d cycles, required 1", n);
    end
    valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid_o0"}, {31'b0, vo0}, 32'd0);
    check({tag, "_valid_o1"}, {31'b0, vo1}, 32'd0);
    check({tag, "_valid_o2"}, {31'b0, vo2}, 32'd0);
    check({tag, "_ready_o0"}, {31'b0, ro0}, 32'd1);
    check({tag, "_fp_o0"}, fp0, 32'd0);
    check({tag, "_fp_o1"}, {16'h0, fp1}, 32'd0);
    check({tag, "_fp_o2"}, {16'h0, fp2}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1; fix = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: basic values, latency
    send(32'd1); send(32'hFFFF_FFFF); send(32'd0);
    idle(6);
    check("t1_count", 32'(out_q0.size()), 32'd3);
    check("t1_lat0", 32'(lat_q[0]), 32'd3);
    check("t1_lat2", 32'(lat_q[2]), 32'd3);

    // 2-4: extremes, half-precision overflow, underflow
    send(32'h8000_0000); send(32'h7FFF_FFFF); send(32'd16777217);
    send(32'd65504); send(32'd65536); send(32'd65520); send(32'hFFFF_0000);
    send(32'd1); send(32'hFFFF_FFFF); send(32'd1024);
    idle(6);
    check("sp_one",      out_q0[0], 32'h3F80_0000);
    check("sp_minus1",   out_q0[1], 32'hBF80_0000);
    check("sp_zero",     out_q0[2], 32'h0000_0000);
    check("sp_minint",   out_q0[3], 32'hCF00_0000);
    check("sp_maxint",   out_q0[4], 32'h4F00_0000);
    check("sp_tie",      out_q0[5], 32'h4B80_0001);
    check("hp_65504",    out_q1[6], 32'h7BFF);
    check("hp_65536",    out_q1[7], SAT ? 32'h7BFF : 32'h7C00);
    check("hp_65520",    out_q1[8], SAT ? 32'h7BFF : 32'h7C00);
    check("hp_m65536",   out_q1[9], SAT ? 32'hFBFF : 32'hFC00);
    check("hq_tiny",     out_q2[10], 32'h0000);
    check("hq_mtiny",    out_q2[11], 32'h8000);
    check("hq_minnorm",  out_q2[12], 32'h0400);

    // 5: backpressure mid-stream
    fork
      begin
        for (int i = 1; i <= 6; i++) send(32'(i));
      end
      begin
        repeat (3) begin @(posedge clk); #1; end
        ready_i = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        ready_i = 1'b1;
      end
    join
    idle(10);
    check("t5_count", 32'(out_q0.size()), 32'd19);
    check("t5_first", out_q0[13], 32'h3F80_0000);
    check("t5_third", out_q0[15], 32'h4040_0000);
    check("t5_last",  out_q0[18], 32'h40C0_0000);

    // 6: reset with three items in flight
    send(32'd10); send(32'd20); send(32'd30);
    ready_i = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; ready_i = 1'b1;
    @(negedge clk);
    check_reset_state("midreset");
    @(posedge clk); #1;
    base = out_q0.size();
    send(32'd256);
    idle(6);
    check("t6_count", 32'(out_q0.size()), 32'(base + 1));
    check("t6_value", out_q0[base], 32'h4380_0000);
    check("t6_lat",   32'(lat_q[lat_q.size() - 1]), 32'd3);

    check("drained0", 32'(exp_q0.size()), 32'd0);
    check("drained1", 32'(exp_q1.size()), 32'd0);
    check("drained2", 32'(exp_q2.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fixed_to_floating_point_converter.md
Name: fixed_to_floating_point_converter

Overview:
- Pipelined converter from signed two's-complement fixed-point to the team's parameterised IEEE-754-style format {sign | exponent | fraction}.
- Sits directly upstream of floating_point_multiplier and produces its fp_a_i/fp_b_i operands from sensor/integer datapaths.
- Output format rules match the multiplier: subnormals flush to zero, and exponent all-ones means infinity.
- Uses a valid/ready handshake with full-pipeline stall on backpressure.

Parameters:
- EXP_WIDTH, 8, exponent bits; BIAS = 2^(EXP_WIDTH-1)-1, EXP_MAX = 2^EXP_WIDTH-1.
- FRAC_WIDTH, 23, stored fraction bits (hidden lead bit not stored).
- INT_WIDTH, 32, total input width including sign (>= 2).
- FIXED_FRAC_BITS, 0, binary point position of the input (0 = integer; may be >= INT_WIDTH).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- fix_i  in  INT_WIDTH  signed fixed-point operand; value = fix_i * 2^-FIXED_FRAC_BITS.
- valid_i  in  1  fix_i valid.
- ready_o  out  1  converter can accept; transfer occurs when valid_i && ready_o.
- fp_o  out  1+EXP_WIDTH+FRAC_WIDTH  converted result.
- valid_o  out  1  fp_o valid.
- ready_i  in  1  downstream accepts; transfer occurs when valid_o && ready_i.

Behaviour:
- Reset: rst_ni low at a clock edge clears all stage valid bits.
  - After reset: valid_o=0, ready_o=1, fp_o=0.
  - Data registers are not reset, except the output register, which resets to 0.
  - Reset mid-operation discards all in-flight items; nothing is emitted for them.
- Pipeline: 3 register stages with a global enable en = !valid_o || ready_i.
  - ready_o = en (combinational from valid_o, ready_i).
  - Stage 1 (accept): register fix_i and valid_i.
  - Stage 2 (magnitude/LZC): compute sign; magnitude = |fix_i| as unsigned INT_WIDTH, so -2^(INT_WIDTH-1) is representable; compute leading-zero count lzc; flag zero.
  - Stage 3 (normalise/round/pack): described below; writes fp_o/valid_o.
- Latency: exactly 3 cycles from acceptance to valid_o with no stall. Throughput is 1/cycle.
- Stall: when en=0, every stage holds.
  - fp_o and valid_o remain stable while valid_o && !ready_i.
  - Bubbles do not collapse.
- Exponent: e = (INT_WIDTH-1-lzc) - FIXED_FRAC_BITS.
  - Evaluated signed, with width sufficient for the INT_WIDTH and FIXED_FRAC_BITS range; no wrap.
- Mantissa: left-shift magnitude by lzc; lead bit = MSB; take the next FRAC_WIDTH bits.
  - Round to nearest, ties away from zero: add 1 if the first discarded bit is 1.
  - If INT_WIDTH-1 <= FRAC_WIDTH, there are no discarded bits and the result is exact.
  - Rounding carry-out: mantissa becomes 1.0 and e increments.
- Packing:
  - magnitude 0 gives fp_o = all zeros (positive zero, even when fix_i is 0 of either sign convention).
  - e + BIAS <= 0 (below min normal) flushes to signed zero: {sign, 0, 0}.
  - e + BIAS >= EXP_MAX, including after rounding carry, gives infinity: {sign, EXP_MAX, 0}.
  - Otherwise {sign, e+BIAS, rounded fraction}.
- Simultaneous accept and emit in the same cycle is legal. No ordering changes; results appear in input order.

Optional Feature:
- Macro: FIXED_TO_FP_SATURATE_EN.
- Defined: overflow produces the largest finite value, {sign, EXP_MAX-1, all-ones fraction}, instead of infinity.
- Undefined: overflow produces infinity as above.
- Zero and underflow behaviour is unchanged either way.

Test Plan:
1. Defaults, ready_i=1.
   - Inputs 1, -1, 0 on consecutive cycles.
   - Required: fp_o 0x3F800000, 0xBF800000, 0x00000000 on cycles 3, 4, 5 after the first accept.
2. Defaults, extremes.
   - 0x80000000 -> 0xCF000000.
   - 0x7FFFFFFF -> 0x4F000000 (rounding carry).
   - 16777217 -> 0x4B800001 (tie rounds away from zero).
3. EXP_WIDTH=5, FRAC_WIDTH=10, INT_WIDTH=32.
   - 65504 -> 0x7BFF.
   - 65536 -> 0x7C00.
   - 65520 -> 0x7C00 (overflow via rounding).
   - -65536 -> 0xFC00.
   - With FIXED_TO_FP_SATURATE_EN: 65536 -> 0x7BFF and -65536 -> 0xFBFF.
4. Half format with FIXED_FRAC_BITS=24.
   - Input 1 (2^-24) -> 0x0000.
   - Input -1 -> 0x8000.
   - Input 2^10 (2^-14) -> 0x0400.
5. Backpressure.
   - Stream 1..6 with ready_i low for 4 cycles mid-stream.
   - Required: ready_o low while valid_o && !ready_i; fp_o held stable; all six results emitted in order with none lost or duplicated.
6. Reset mid-stream.
   - Drive rst_ni low for 1 cycle with 3 items in flight.
   - Required: next cycle valid_o=0, ready_o=1, fp_o=0; no stale result emitted; the following input is converted correctly with latency 3.
